// File: rtl/anton_neopixel_bus_master.sv
// anton_neopixel_bus_master: uploads a source byte stream into a controller region, then optionally kicks its registers
module anton_neopixel_bus_master #(
  parameter int ADDR_BITS = 18
) (
  input  logic                 busClk,
  input  logic                 busRstN,
  input  logic                 start,
  input  logic [1:0]           region,
  input  logic [15:0]          baseAddr,
  input  logic [16:0]          count,
  input  logic                 kick,
  input  logic [12:0]          maxValue,
  input  logic [4:0]           ctrlValue,
  input  logic [7:0]           srcData,
  input  logic                 srcValid,
  output logic                 srcReady,
  output logic [ADDR_BITS-1:0] busAddr,
  output logic [7:0]           busDataOut,
  output logic                 busWrite,
  output logic                 busRead,
  input  logic                 busReady,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, GAP, WAIT, REG, DONE, ERR} state_t;
  state_t      state;
  logic [1:0]  rgn;
  logic [15:0] base;
  logic [16:0] cnt;
  logic [16:0] idx;
  logic        kck;
  logic [12:0] mx;
  logic [4:0]  ctl;
  logic [1:0]  kidx;
  logic        kph;
  assign busRead = 1'b0;
  // single FSM: every output is registered and set on the edge that enters its state
  always_ff @(posedge busClk) begin
    if (!busRstN) begin
      state      <= IDLE;
      rgn        <= '0;
      base       <= '0;
      cnt        <= '0;
      idx        <= '0;
      kck        <= 1'b0;
      mx         <= '0;
      ctl        <= '0;
      kidx       <= '0;
      kph        <= 1'b0;
      srcReady   <= 1'b0;
      busAddr    <= '0;
      busDataOut <= '0;
      busWrite   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      busWrite <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rgn  <= region;
          base <= baseAddr;
          cnt  <= count;
          kck  <= kick;
          mx   <= maxValue;
          ctl  <= ctrlValue;
          idx  <= '0;
          kidx <= '0;
          kph  <= 1'b0;
          busy <= 1'b1;
          if (region == 2'b11 || (region == 2'b01 && (baseAddr[0] || count[0]))) begin
            state <= ERR;
            error <= 1'b1;
          end else if (count != '0) begin
            state    <= FETCH;
            srcReady <= 1'b1;
          end else if (kick) begin
            state <= REG;
            kph   <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        FETCH: if (srcValid) begin
          srcReady   <= 1'b0;
          busWrite   <= 1'b1;
          busAddr    <= {rgn, 16'(base + idx[15:0])};
          busDataOut <= srcData;
          state      <= WRITE;
        end
        REG: begin
          busWrite   <= 1'b1;
          busAddr    <= {2'b11, 14'd0, kidx};
          busDataOut <= kidx == 2'd0 ? mx[7:0] : kidx == 2'd1 ? {3'b000, mx[12:8]} : {3'b000, ctl};
          state      <= WRITE;
        end
        WRITE: state <= GAP;
        GAP:   state <= WAIT;
        WAIT: if (busReady) begin
          if (kph) begin
            if (kidx == 2'd2) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              kidx  <= 2'(kidx + 2'd1);
              state <= REG;
            end
          end else begin
            idx <= 17'(idx + 17'd1);
            if (17'(idx + 17'd1) == cnt) begin
              if (kck) begin
                state <= REG;
                kph   <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              state    <= FETCH;
              srcReady <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anton_neopixel_bus_master.sv
// tb_anton_neopixel_bus_master: directed scenario bench with a source queue, delayed-ready responder and write log
module tb_anton_neopixel_bus_master;
  logic        busClk = 1'b0;
  logic        busRstN = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  region = '0;
  logic [15:0] baseAddr = '0;
  logic [16:0] count = '0;
  logic        kick = 1'b0;
  logic [12:0] maxValue = '0;
  logic [4:0]  ctrlValue = '0;
  logic [7:0]  srcData;
  logic        srcValid, srcReady;
  logic [17:0] busAddr;
  logic [7:0]  busDataOut;
  logic        busWrite, busRead, busReady, busy, done, error;
  int checks = 0;
  int errors = 0;

  anton_neopixel_bus_master dut (
    .busClk(busClk), .busRstN(busRstN), .start(start), .region(region), .baseAddr(baseAddr),
    .count(count), .kick(kick), .maxValue(maxValue), .ctrlValue(ctrlValue), .srcData(srcData),
    .srcValid(srcValid), .srcReady(srcReady), .busAddr(busAddr), .busDataOut(busDataOut),
    .busWrite(busWrite), .busRead(busRead), .busReady(busReady), .busy(busy), .done(done), .error(error)
  );

  always #5 busClk = ~busClk;

  // source stream: bytes from src_mem, paused while src_hold is set
  logic [7:0] src_mem [64];
  int src_ptr = 0;
  int src_n = 0;
  logic src_hold = 1'b0;
  assign srcValid = (src_ptr < src_n) && !src_hold;
  assign srcData  = src_mem[src_ptr[5:0]];
  always @(posedge busClk) if (srcValid && srcReady) src_ptr <= src_ptr + 1;

  // responder: busReady drops for rdelay cycles after each write
  int rdelay = 1;
  int rcnt = 0;
  always @(posedge busClk) if (busWrite) rcnt <= rdelay; else if (rcnt > 0) rcnt <= rcnt - 1;
  assign busReady = (rcnt == 0);

  // cycle counter and bus/pulse log sampled mid-cycle
  int cyc = 0;
  always @(posedge busClk) cyc <= cyc + 1;
  logic [17:0] wa [64];
  logic [7:0]  wd [64];
  int wc [64];
  int wn = 0, dn = 0, en = 0, dc = 0, ec = 0;
  always @(negedge busClk) begin
    if (busWrite && wn < 64) begin
      wa[wn] = busAddr;
      wd[wn] = busDataOut;
      wc[wn] = cyc;
      wn++;
    end
    if (done) begin dn++; dc = cyc; end
    if (error) begin en++; ec = cyc; end
  end

  task automatic load_src(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) src_mem[6'(src_ptr + i)] = v[8*(n-1-i) +: 8];
    src_n = src_ptr + n;
  endtask

  task automatic do_start(input logic [1:0] r, input logic [15:0] b, input logic [16:0] c, input logic k,
                          input logic [12:0] m, input logic [4:0] ct, output int s);
    @(negedge busClk);
    region = r; baseAddr = b; count = c; kick = k; maxValue = m; ctrlValue = ct;
    start = 1'b1;
    s = cyc;
    @(negedge busClk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, output bit to);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (dn > d0 || en > e0) begin to = 1'b0; break; end
      @(negedge busClk);
    end
    repeat (2) @(negedge busClk);
  endtask

  task automatic test_reset;
    busRstN = 1'b0;
    repeat (3) @(negedge busClk);
    checks++;
    if ({busy, done, error, busWrite, busRead, srcReady, busAddr, busDataOut} !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b error=%0b wr=%0b rd=%0b rdy=%0b addr=%h data=%h, want all 0",
               busy, done, error, busWrite, busRead, srcReady, busAddr, busDataOut);
    end
    busRstN = 1'b1;
    @(negedge busClk);
  endtask

  task automatic test_raw;
    int s, w0, d0, e0;
    bit to;
    logic [23:0] exp_d = 24'hAABBCC;
    rdelay = 1; w0 = wn; d0 = dn; e0 = en;
    load_src(3, 64'hAABBCC);
    do_start(2'b10, 16'h0010, 17'd3, 1'b0, 13'd0, 5'd0, s);
    wait_end(d0, e0, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL raw_timeout: no done/error within bound"); end
    checks++;
    if (wn - w0 !== 3) begin errors++; $display("FAIL raw_count: got %0d writes, want 3", wn - w0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wa[w0+i] !== 18'h20010 + 18'(i) || wd[w0+i] !== exp_d[8*(2-i) +: 8] || wc[w0+i] !== s + 2 + 4*i) begin
        errors++;
        $display("FAIL raw_write%0d: got %h=%h @%0d, want %h=%h @%0d", i, wa[w0+i], wd[w0+i], wc[w0+i] - s,
                 18'h20010 + 18'(i), exp_d[8*(2-i) +: 8], 2 + 4*i);
      end
    end
    checks++;
    if (dn !== d0 + 1 || dc !== s + 13 || en !== e0) begin
      errors++;
      $display("FAIL raw_done: got %0d done pulses at +%0d errors %0d, want 1 at +13 errors 0", dn - d0, dc - s, en - e0);
    end
  endtask

  task automatic test_delta_kick;
    int s, w0, d0, e0;
    bit to;
    logic [17:0] ea [7] = '{18'h10004, 18'h10005, 18'h10006, 18'h10007, 18'h30000, 18'h30001, 18'h30002};
    logic [7:0]  ed [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h34, 8'h12, 8'h04};
    rdelay = 1; w0 = wn; d0 = dn; e0 = en;
    load_src(4, 64'h11223344);
    do_start(2'b01, 16'h0004, 17'd4, 1'b1, 13'h1234, 5'h04, s);
    wait_end(d0, e0, to);
    checks++;
    if (to !== 1'b0 || wn - w0 !== 7) begin
      errors++;
      $display("FAIL delta_count: got %0d writes (timeout=%0b), want 7", wn - w0, to);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (wa[w0+i] !== ea[i] || wd[w0+i] !== ed[i]) begin
        errors++;
        $display("FAIL delta_write%0d: got %h=%h, want %h=%h", i, wa[w0+i], wd[w0+i], ea[i], ed[i]);
      end
    end
    checks++;
    if (dn !== d0 + 1 || en !== e0) begin
      errors++;
      $display("FAIL delta_done: got done %0d error %0d, want 1 and 0", dn - d0, en - e0);
    end
  endtask

  task automatic test_illegal;
    int s, w0, d0, e0;
    bit to;
    logic [1:0]  rr [2] = '{2'b11, 2'b01};
    logic [16:0] cc [2] = '{17'd2, 17'd3};
    for (int i = 0; i < 2; i++) begin
      w0 = wn; d0 = dn; e0 = en;
      do_start(rr[i], 16'h0000, cc[i], 1'b1, 13'h0AA, 5'h1, s);
      wait_end(d0, e0, to);
      checks++;
      if (to !== 1'b0 || en !== e0 + 1 || ec !== s + 1 || wn !== w0 || dn !== d0) begin
        errors++;
        $display("FAIL illegal%0d: got error %0d at +%0d, writes %0d, done %0d; want error 1 at +1, no writes, no done",
                 i, en - e0, ec - s, wn - w0, dn - d0);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s, w0, d0, e0, rel;
    bit to;
    rdelay = 5; w0 = wn; d0 = dn; e0 = en;
    src_hold = 1'b1;
    load_src(2, 64'h5A6B);
    do_start(2'b00, 16'hFFFF, 17'd2, 1'b0, 13'd0, 5'd0, s);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (srcReady !== 1'b1 || wn !== w0) begin
        errors++;
        $display("FAIL gap_hold%0d: got srcReady=%0b writes=%0d, want 1 and 0", i, srcReady, wn - w0);
      end
      @(negedge busClk);
    end
    rel = cyc;
    src_hold = 1'b0;
    wait_end(d0, e0, to);
    checks++;
    if (to !== 1'b0 || wn - w0 !== 2 || dn !== d0 + 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes done %0d, want 2 and 1", wn - w0, dn - d0);
    end
    checks++;
    if (wa[w0] !== 18'h0FFFF || wd[w0] !== 8'h5A || wc[w0] !== rel + 1) begin
      errors++;
      $display("FAIL wrap_first: got %h=%h @%0d, want 0ffff=5a @%0d", wa[w0], wd[w0], wc[w0], rel + 1);
    end
    checks++;
    if (wa[w0+1] !== 18'h00000 || wd[w0+1] !== 8'h6B || wc[w0+1] - wc[w0] !== 8) begin
      errors++;
      $display("FAIL wrap_second: got %h=%h spacing %0d, want 00000=6b spacing 8", wa[w0+1], wd[w0+1], wc[w0+1] - wc[w0]);
    end
    rdelay = 1;
  endtask

  task automatic test_zero;
    int s, w0, d0, e0;
    bit to;
    w0 = wn; d0 = dn; e0 = en;
    do_start(2'b10, 16'h0000, 17'd0, 1'b0, 13'd0, 5'd0, s);
    wait_end(d0, e0, to);
    checks++;
    if (to !== 1'b0 || dn !== d0 + 1 || dc !== s + 1 || wn !== w0) begin
      errors++;
      $display("FAIL zero_nokick: got done %0d at +%0d writes %0d, want 1 at +1 and 0", dn - d0, dc - s, wn - w0);
    end
    w0 = wn; d0 = dn;
    do_start(2'b10, 16'h0000, 17'd0, 1'b1, 13'h1FFF, 5'h1F, s);
    wait_end(d0, e0, to);
    checks++;
    if (to !== 1'b0 || wn - w0 !== 3 || dn !== d0 + 1 ||
        wa[w0] !== 18'h30000 || wd[w0] !== 8'hFF || wa[w0+1] !== 18'h30001 || wd[w0+1] !== 8'h1F ||
        wa[w0+2] !== 18'h30002 || wd[w0+2] !== 8'h1F) begin
      errors++;
      $display("FAIL zero_kick: got %0d writes %h=%h %h=%h %h=%h done %0d, want 30000=ff 30001=1f 30002=1f done 1",
               wn - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1], wa[w0+2], wd[w0+2], dn - d0);
    end
  endtask

  task automatic test_reset_mid;
    int s, w0, d0, e0;
    bit to, seen;
    rdelay = 1; w0 = wn; d0 = dn; e0 = en;
    load_src(5, 64'h0102030405);
    do_start(2'b10, 16'h0100, 17'd5, 1'b0, 13'd0, 5'd0, s);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wn == w0 + 2) begin seen = 1'b1; break; end
      @(negedge busClk);
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL mid_second_write: got %0d writes, want 2", wn - w0); end
    busRstN = 1'b0;
    @(negedge busClk);
    checks++;
    if ({busy, done, error, busWrite, srcReady, busAddr, busDataOut} !== 31'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%0b wr=%0b rdy=%0b addr=%h data=%h, want all 0",
               busy, busWrite, srcReady, busAddr, busDataOut);
    end
    busRstN = 1'b1;
    repeat (20) @(negedge busClk);
    checks++;
    if (dn !== d0 || en !== e0 || wn !== w0 + 2) begin
      errors++;
      $display("FAIL mid_silent: got done %0d error %0d writes %0d, want 0 0 2", dn - d0, en - e0, wn - w0);
    end
    w0 = wn; d0 = dn;
    load_src(2, 64'hE1E2);
    do_start(2'b10, 16'h0100, 17'd2, 1'b0, 13'd0, 5'd0, s);
    wait_end(d0, e0, to);
    checks++;
    if (to !== 1'b0 || wn - w0 !== 2 || dn !== d0 + 1 ||
        wa[w0] !== 18'h20100 || wd[w0] !== 8'hE1 || wa[w0+1] !== 18'h20101 || wd[w0+1] !== 8'hE2) begin
      errors++;
      $display("FAIL mid_restart: got %0d writes %h=%h %h=%h done %0d, want 20100=e1 20101=e2 done 1",
               wn - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1], dn - d0);
    end
  endtask

  initial begin
    test_reset;
    test_raw;
    test_delta_kick;
    test_illegal;
    test_back_to_back;
    test_zero;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
